wb_rr_master_arbiter: RTL

//  Round-robin arbiter sharing one Wishbone slave port between NUM_MASTERS

---
 rtl/wb_rr_master_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/wb_rr_master_arbiter.sv
// Round-robin arbiter that shares one Wishbone slave port between NUM_MASTERS masters.
// A grant is held for a whole CYC; a watchdog aborts stalled slave cycles with ERR.
module wb_rr_master_arbiter #(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned WB_ADDR_WIDTH  = 32,
  parameter int unsigned WB_DATA_WIDTH  = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                                   clk_i,
  input  logic                                   rst_n_i,
  input  logic [NUM_MASTERS*WB_ADDR_WIDTH-1:0]   m_ADR,
  input  logic [NUM_MASTERS*WB_DATA_WIDTH-1:0]   m_DAT_W,
  input  logic [NUM_MASTERS*WB_DATA_WIDTH/8-1:0] m_SEL,
  input  logic [NUM_MASTERS-1:0]                 m_CYC,
  input  logic [NUM_MASTERS-1:0]                 m_STB,
  input  logic [NUM_MASTERS-1:0]                 m_WE,
  output logic [WB_DATA_WIDTH-1:0]               m_DAT_R,
  output logic [NUM_MASTERS-1:0]                 m_ACK,
  output logic [NUM_MASTERS-1:0]                 m_ERR,
  output logic [WB_ADDR_WIDTH-1:0]               s_ADR,
  output logic [WB_DATA_WIDTH-1:0]               s_DAT_W,
  output logic [WB_DATA_WIDTH/8-1:0]             s_SEL,
  output logic                                   s_CYC,
  output logic                                   s_STB,
  output logic                                   s_WE,
  input  logic [WB_DATA_WIDTH-1:0]               s_DAT_R,
  input  logic                                   s_ACK,
  input  logic                                   s_ERR,
  output logic [NUM_MASTERS-1:0]                 grant_o,
  output logic                                   timeout_o
);

  localparam int unsigned N       = NUM_MASTERS;
  localparam int unsigned AW      = WB_ADDR_WIDTH;
  localparam int unsigned DW      = WB_DATA_WIDTH;
  localparam int unsigned SW      = WB_DATA_WIDTH / 8;
  localparam int unsigned IW      = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned WW      = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

  typedef struct packed {
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
    logic          we;
    logic          cyc;
    logic          stb;
  } wb_req_t;

  state_t        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] gidx_q, gidx_d;
  logic [IW-1:0] last_q, last_d;
  logic [WW-1:0] wdog_q, wdog_d;

  wb_req_t       req_sel;
  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] cand;
  logic          wdog_hit;

  assign m_DAT_R  = s_DAT_R;
  assign grant_o  = grant_q;
  assign wdog_hit = (TIMEOUT_CYCLES != 0) && (wdog_q == WW'(TO_LAST));

  // Request fields of the currently granted master
  always_comb begin
    req_sel = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (gidx_q == IW'(i)) begin
        req_sel.adr = m_ADR[i*AW +: AW];
        req_sel.dat = m_DAT_W[i*DW +: DW];
        req_sel.sel = m_SEL[i*SW +: SW];
        req_sel.we  = m_WE[i];
        req_sel.cyc = m_CYC[i];
        req_sel.stb = m_STB[i];
      end
    end
  end

  // First requester after the last owner, wrapping modulo N
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= int'(N); k++) begin
      cand = IW'((int'(last_q) + k) % int'(N));
      if (!win_found && m_CYC[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IW'(N - 1);
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    last_d    = last_q;
    wdog_d    = '0;
    s_ADR     = '0;
    s_DAT_W   = '0;
    s_SEL     = '0;
    s_WE      = 1'b0;
    s_CYC     = 1'b0;
    s_STB     = 1'b0;
    m_ACK     = '0;
    m_ERR     = '0;
    timeout_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = BUSY;
          gidx_d  = win_idx;
          grant_d = {{(N-1){1'b0}}, 1'b1} << win_idx;
        end
      end

      BUSY: begin
        s_ADR   = req_sel.adr;
        s_DAT_W = req_sel.dat;
        s_SEL   = req_sel.sel;
        s_WE    = req_sel.we;
        s_CYC   = req_sel.cyc;
        s_STB   = req_sel.cyc & req_sel.stb;
        if (!req_sel.cyc) begin
          state_d = IDLE;
          last_d  = gidx_q;
          grant_d = '0;
        end else if (req_sel.stb) begin
          m_ACK[gidx_q] = s_ACK;
          m_ERR[gidx_q] = s_ERR;
          // Stalled strobe: count, or abort once the budget is used up
          if (!s_ACK && !s_ERR) begin
            if (wdog_hit) begin
              m_ERR[gidx_q] = 1'b1;
              timeout_o     = 1'b1;
              state_d       = ABORT;
            end else begin
              wdog_d = wdog_q + WW'(1);
            end
          end
        end
      end

      ABORT: begin
        if (!req_sel.cyc) begin
          state_d = IDLE;
          last_d  = gidx_q;
          grant_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

endmodule
